// File: rtl/instr_sequencer_pkg.sv
// cpu_pkg: shared definitions for the 4-bit accumulator CPU control path.
//   - opcode constants seen by the instruction sequencer and decoder
//   - seq_state_t, the instruction sequencer state encoding
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_IN   = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_IN = 2'd2,
    HALT    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: decoder-side bundle of the instruction sequencer.
//   InstrIn   opcode from the instruction register (valid Phase1..Phase3)
//   InValid   external input port holds data for IN
//   InAck     one-cycle pulse, input data consumed
//   Phase0..3 one-hot phase strobes to the microinstruction decoder
// Modports:
//   master  the sequencer (drives phases and InAck)
//   slave   the decoder / input-port side
interface instr_sequencer_if;

  logic [3:0] InstrIn;
  logic       InValid;
  logic       InAck;
  logic       Phase0;
  logic       Phase1;
  logic       Phase2;
  logic       Phase3;

  modport master (
    input  InstrIn, InValid,
    output InAck, Phase0, Phase1, Phase2, Phase3
  );

  modport slave (
    output InstrIn, InValid,
    input  InAck, Phase0, Phase1, Phase2, Phase3
  );

endinterface

// File: rtl/instr_sequencer_phase_ring.sv
// phase_ring: 4-bit one-hot phase ring register.
//   Clk      system clock
//   ResetN   asynchronous active-low reset, clears the ring
//   advance  step to the next phase; from all-zero it starts at phase 0
//   hold     keep the current phase (wins over advance)
//   clear    force all phases low (wins over hold and advance)
//   phase    registered one-hot phase, bit n = Phase n
module phase_ring (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       advance,
  input  logic       hold,
  input  logic       clear,
  output logic [3:0] phase
);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      phase <= 4'b0000;
    end else if (clear) begin
      phase <= 4'b0000;
    end else if (hold) begin
      phase <= phase;
    end else if (advance) begin
      // An empty ring is how IDLE/HALT look; advancing out of it starts Phase0.
      phase <= (phase == 4'b0000) ? 4'b0001 : {phase[2:0], phase[3]};
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: four-phase instruction sequencer for the 4-bit accumulator CPU.
// Drives one-hot Phase0..Phase3 to the microinstruction decoder, latches the
// opcode at the end of Phase1, stalls IN in Phase2 until InValid, stops on HLT.
//
// Ports:
//   Clk         system clock
//   ResetN      asynchronous active-low reset
//   Run         level, execute continuously
//   Step        single-instruction pulse (used only with SEQ_STEP_EN)
//   bus         instr_sequencer_if.master: InstrIn, InValid, InAck, Phase0..3
//   Running     state is RUN or WAIT_IN
//   Halted      state is HALT
//   InstrCount  retired instructions, saturating at all-ones
//
// Build option: define SEQ_STEP_EN to let a Step pulse in IDLE run exactly one
// instruction. Without it Step is ignored.
//
// state   | meaning
// IDLE    | no instruction active, phases low, waiting for Run (or Step)
// RUN     | executing, ring advances one phase per cycle
// WAIT_IN | IN stalled in Phase2 until InValid
// HALT    | HLT executed, phases low, left only by reset
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 Run,
  input  logic                 Step,
  instr_sequencer_if.master    bus,
  output logic                 Running,
  output logic                 Halted,
  output logic [CNT_W-1:0]     InstrCount
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic [3:0] phase;
  logic [3:0] op_reg;
  logic       ring_adv;
  logic       ring_hold;
  logic       ring_clr;
  logic       in_ack;
  logic       capture;
  logic       retire;
  logic       start;

`ifdef SEQ_STEP_EN
  // Run=Step=1 still runs continuously: Run is re-sampled at every Phase3.
  assign start = Run | Step;
`else
  logic unused_step;
  assign unused_step = Step;
  assign start       = Run;
`endif

  phase_ring u_ring (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .advance (ring_adv),
    .hold    (ring_hold),
    .clear   (ring_clr),
    .phase   (phase)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ring_adv  = 1'b0;
    ring_hold = 1'b0;
    ring_clr  = 1'b0;
    in_ack    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          ring_adv  = 1'b1;
        end
      end
      RUN: begin
        if (phase[1]) begin
          capture = 1'b1;
          // HLT is decided from the opcode being latched, so the sequencer
          // stops right after Phase1 and the instruction never retires.
          if (bus.InstrIn == OP_HLT) begin
            state_nxt = HALT;
            ring_clr  = 1'b1;
          end else begin
            ring_adv = 1'b1;
          end
        end else if (phase[2]) begin
          if (op_reg == OP_IN) begin
            if (bus.InValid) begin
              in_ack   = 1'b1;
              ring_adv = 1'b1;
            end else begin
              state_nxt = WAIT_IN;
              ring_hold = 1'b1;
            end
          end else begin
            ring_adv = 1'b1;
          end
        end else if (phase[3]) begin
          retire = 1'b1;
          if (Run) begin
            ring_adv = 1'b1;
          end else begin
            state_nxt = IDLE;
            ring_clr  = 1'b1;
          end
        end else begin
          ring_adv = 1'b1;
        end
      end
      WAIT_IN: begin
        if (bus.InValid) begin
          in_ack    = 1'b1;
          state_nxt = RUN;
          ring_adv  = 1'b1;
        end else begin
          ring_hold = 1'b1;
        end
      end
      HALT: begin
        ring_clr = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ring_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      op_reg <= 4'b0000;
    end else if (capture) begin
      op_reg <= bus.InstrIn;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      InstrCount <= '0;
    end else if (retire && (InstrCount != {CNT_W{1'b1}})) begin
      InstrCount <= InstrCount + CNT_W'(1);
    end
  end

  assign bus.Phase0 = phase[0];
  assign bus.Phase1 = phase[1];
  assign bus.Phase2 = phase[2];
  assign bus.Phase3 = phase[3];
  assign bus.InAck  = in_ack;
  assign Running    = (state == RUN) || (state == WAIT_IN);
  assign Halted     = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer. Expected waveforms are built per instruction
// from the opcode and the planned number of IN wait cycles; the retired count
// is tracked with saturating arithmetic. Step behaviour is checked according
// to whether SEQ_STEP_EN is defined.
module tb_instr_sequencer;
  import cpu_pkg::*;

  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          Clk    = 1'b0;
  logic          ResetN = 1'b0;
  logic          Run    = 1'b0;
  logic          Step   = 1'b0;
  logic          Running;
  logic          Halted;
  logic [CW-1:0] InstrCount;

  int total     = 0;
  int passed    = 0;
  int fails     = 0;
  int exp_count = 0;

  instr_sequencer_if bus();

  instr_sequencer #(.CNT_W(CW)) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .Run        (Run),
    .Step       (Step),
    .bus        (bus),
    .Running    (Running),
    .Halted     (Halted),
    .InstrCount (InstrCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] eph, input logic eack,
                               input logic erun, input logic ehalt);
    chk({tag, ".phase"}, {28'd0, bus.Phase3, bus.Phase2, bus.Phase1, bus.Phase0}, {28'd0, eph});
    chk({tag, ".inack"}, {31'd0, bus.InAck}, {31'd0, eack});
    chk({tag, ".running"}, {31'd0, Running}, {31'd0, erun});
    chk({tag, ".halted"}, {31'd0, Halted}, {31'd0, ehalt});
    chk({tag, ".count"}, 32'(InstrCount), 32'(exp_count));
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input logic [3:0] op, input logic iv, input logic rn, input logic st,
                     input logic [3:0] eph, input logic eack, input logic erun,
                     input logic ehalt, input string tag);
    bus.InstrIn = op;
    bus.InValid = iv;
    Run         = rn;
    Step        = st;
    @(negedge Clk);
    check_outputs(tag, eph, eack, erun, ehalt);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input logic rn, input logic st, input string tag);
    cyc(4'($urandom_range(0, 15)), rb(), rn, st, 4'b0000, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Entered in the Phase0 cycle. rmid is Run during Phase0..Phase2 (not sampled);
  // cont is Run on the Phase3 edge. IN waits nwait cycles with InValid low.
  task automatic do_instr(input logic [3:0] op, input int nwait, input logic cont,
                          input logic rmid, input string tag);
    cyc(op, rb(), rmid, rb(), 4'b0001, 1'b0, 1'b1, 1'b0, {tag, ".p0"});
    cyc(op, rb(), rmid, rb(), 4'b0010, 1'b0, 1'b1, 1'b0, {tag, ".p1"});
    if (op == OP_HLT) return;
    if (op == OP_IN) begin
      for (int k = 0; k <= nwait; k++)
        cyc(op, k == nwait, rmid, rb(), 4'b0100, k == nwait, 1'b1, 1'b0, {tag, ".p2in"});
    end else begin
      cyc(op, rb(), rmid, rb(), 4'b0100, 1'b0, 1'b1, 1'b0, {tag, ".p2"});
    end
    cyc(op, rb(), cont, rb(), 4'b1000, 1'b0, 1'b1, 1'b0, {tag, ".p3"});
    if (exp_count < MAXC) exp_count++;
  endtask

  initial begin
    logic [3:0] op;
    int         nw;
    logic       cont;

    bus.InstrIn = 4'b0000;
    bus.InValid = 1'b0;
    @(posedge Clk);
    #1;
    exp_count = 0;
    cyc(OP_ADD, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "reset");
    ResetN = 1'b1;

    // Continuous ADDs, then an IN stalled 5 cycles, then OUT with Run dropped.
    idle(1'b1, 1'b0, "start");
    do_instr(OP_ADD, 0, 1'b1, 1'b1, "add0");
    do_instr(OP_ADD, 0, 1'b1, 1'b1, "add1");
    do_instr(OP_ADD, 0, 1'b1, 1'b1, "add2");
    do_instr(OP_IN, 5, 1'b1, 1'b1, "in5");
    do_instr(OP_OUT, 0, 1'b0, 1'b1, "out");
    idle(1'b0, 1'b0, "idle0");

`ifdef SEQ_STEP_EN
    idle(1'b0, 1'b1, "step_go");
    do_instr(OP_LOAD, 0, 1'b0, 1'b0, "step");
    idle(1'b0, 1'b0, "step_idle");
    idle(1'b0, 1'b1, "stepin_go");
    do_instr(OP_IN, 2, 1'b0, 1'b0, "step_in");
    idle(1'b0, 1'b0, "stepin_idle");
    idle(1'b1, 1'b1, "runstep_go");
    do_instr(OP_NOP, 0, 1'b1, 1'b1, "runstep0");
    do_instr(OP_SUB, 0, 1'b0, 1'b1, "runstep1");
    idle(1'b0, 1'b0, "runstep_idle");
`else
    idle(1'b0, 1'b1, "step_ign0");
    idle(1'b0, 1'b1, "step_ign1");
    idle(1'b0, 1'b0, "step_ign2");
`endif

    // Run low from Phase0 on: the instruction still completes, then IDLE.
    idle(1'b1, 1'b0, "drop_go");
    do_instr(OP_SUB, 0, 1'b0, 1'b0, "drop");
    idle(1'b0, 1'b0, "drop_idle");

    // Random non-HLT program; the count saturates along the way.
    idle(1'b1, 1'b0, "rnd_go");
    for (int i = 0; i < 24; i++) begin
      op   = 4'($urandom_range(0, 14));
      nw   = $urandom_range(0, 4);
      cont = (i == 23) ? 1'b0 : ($urandom_range(0, 3) != 0);
      do_instr(op, nw, cont, rb(), "rnd");
      if (!cont && i != 23) begin
        idle(1'b0, 1'b0, "rnd_idle");
`ifdef SEQ_STEP_EN
        if (rb()) idle(1'b0, 1'b1, "rnd_restep");
        else      idle(1'b1, 1'b0, "rnd_rerun");
`else
        idle(1'b1, 1'b0, "rnd_rerun");
`endif
      end
    end
    idle(1'b0, 1'b0, "rnd_end");

    // HLT: phases drop after Phase1, no retire, Run/Step have no effect.
    exp_count = 0;
    ResetN = 1'b0;
    cyc(OP_NOP, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "rst_hlt");
    ResetN = 1'b1;
    idle(1'b1, 1'b0, "hlt_go");
    do_instr(OP_ADD, 0, 1'b1, 1'b1, "prehlt");
    do_instr(OP_HLT, 0, 1'b1, 1'b1, "hlt");
    for (int i = 0; i < 5; i++)
      cyc(4'($urandom_range(0, 15)), rb(), i[0], rb(), 4'b0000, 1'b0, 1'b0, 1'b1, "halted");

    // Reset leaves HALT.
    exp_count = 0;
    ResetN = 1'b0;
    cyc(OP_NOP, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "rst2");
    ResetN = 1'b1;

    // Reset asserted while stalled in WAIT_IN clears outputs before any edge.
    idle(1'b1, 1'b0, "w_go");
    cyc(OP_IN, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, "w.p0");
    cyc(OP_IN, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, "w.p1");
    cyc(OP_IN, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, "w.p2");
    cyc(OP_IN, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, "w.wait");
    bus.InValid = 1'b1;
    ResetN      = 1'b0;
    #1;
    exp_count = 0;
    check_outputs("w.async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(OP_IN, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "w.rst_hold");
    ResetN = 1'b1;
    idle(1'b1, 1'b0, "after_go");
    do_instr(OP_ADD, 0, 1'b0, 1'b1, "after_rst");
    idle(1'b0, 1'b0, "final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
